// File: rtl/serial_shift_if.sv
// serial_shift_if: start/busy/done handshake plus the external shift-chain pin group
interface serial_shift_if #(parameter int DATA_WIDTH = 64);
  logic start;
  logic [DATA_WIDTH-1:0] data;
  logic busy;
  logic done;
  logic sclk;
  logic sdo;
  logic spen;
  logic sclr_n;
  modport master (output start, data, input busy, done, sclk, sdo, spen, sclr_n);
  modport slave (input start, data, output busy, done, sclk, sdo, spen, sclr_n);
endinterface

// File: rtl/serial_shift_driver.sv
// serial_shift_driver: shifts a parallel word MSB first into an external chain, then latches it
module serial_shift_driver #(
  parameter int DATA_WIDTH = 64,
  parameter int CLK_DIV = 2
) (
  input logic clk,
  input logic rst_n,
  serial_shift_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT_LO = 2'd1, SHIFT_HI = 2'd2, LATCH = 2'd3;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] ph;
  logic ph_end;
  logic last_bit;
  assign ph_end = ph == PW'(CLK_DIV - 1);
  assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      ph <= '0;
      bus.sclk <= 1'b0;
      bus.sdo <= 1'b0;
      bus.spen <= 1'b1;
      bus.sclr_n <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.sclr_n <= 1'b1;
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            sr <= bus.data;
            state <= SHIFT_LO;
            bus.busy <= 1'b1;
            bus.spen <= 1'b0;
            bus.sclk <= 1'b0;
            bus.sdo <= bus.data[DATA_WIDTH-1];
            bit_cnt <= '0;
            ph <= '0;
          end
        SHIFT_LO:
          if (ph_end) begin
            ph <= '0;
            bus.sclk <= 1'b1;
            state <= SHIFT_HI;
          end else ph <= ph + 1'b1;
        SHIFT_HI:
          if (ph_end) begin
            ph <= '0;
            bus.sclk <= 1'b0;
            if (last_bit) begin
              state <= LATCH;
              bus.sdo <= 1'b0;
            end else begin
              // sdo moves only on the sclk falling transition
              sr <= {sr[DATA_WIDTH-2:0], 1'b0};
              bus.sdo <= sr[DATA_WIDTH-2];
              bit_cnt <= bit_cnt + 1'b1;
              state <= SHIFT_LO;
            end
          end else ph <= ph + 1'b1;
        default:
          if (ph_end) begin
            ph <= '0;
            bus.spen <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= IDLE;
          end else ph <= ph + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_serial_shift_driver.sv
// tb_serial_shift_driver: directed tests for an 8-bit/div-1 and a default 64-bit/div-2 driver
module tb_serial_shift_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_shift_if #(.DATA_WIDTH(8)) i8 ();
  serial_shift_if #(.DATA_WIDTH(64)) i64 ();
  serial_shift_driver #(.DATA_WIDTH(8), .CLK_DIV(1)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_shift_driver u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));

  task automatic run8(input logic [7:0] d, output logic [7:0] cap, output int rises,
                      output int busy_n, output int dones, output logic latch_ok);
    logic ps, pspen;
    cap = '0; rises = 0; busy_n = 0; dones = 0; latch_ok = 1'b0;
    ps = i8.sclk; pspen = i8.spen;
    i8.start = 1'b1; i8.data = d;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      @(negedge clk);
      i8.start = 1'b0;
      if (!ps && i8.sclk) begin cap = {cap[6:0], i8.sdo}; rises++; end
      if (i8.busy) busy_n++;
      if (i8.done) begin dones++; latch_ok = i8.spen && !pspen; end
      ps = i8.sclk; pspen = i8.spen;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i8.start = 1'b0; i8.data = '0; i64.start = 1'b0; i64.data = '0;
    repeat (5) begin
      @(negedge clk);
      checks += 2;
      if ({i8.sclk, i8.sdo, i8.spen, i8.sclr_n, i8.busy, i8.done} !== 6'b001000) begin
        errors++; $display("FAIL reset8 pins got %b want 001000", {i8.sclk, i8.sdo, i8.spen, i8.sclr_n, i8.busy, i8.done});
      end
      if ({i64.sclk, i64.sdo, i64.spen, i64.sclr_n, i64.busy, i64.done} !== 6'b001000) begin
        errors++; $display("FAIL reset64 pins got %b want 001000", {i64.sclk, i64.sdo, i64.spen, i64.sclr_n, i64.busy, i64.done});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if ({i8.sclr_n, i8.sclk, i8.spen, i8.busy} !== 4'b1010) begin
      errors++; $display("FAIL release8 sclr_n/sclk/spen/busy got %b want 1010", {i8.sclr_n, i8.sclk, i8.spen, i8.busy});
    end
    if ({i64.sclr_n, i64.sclk, i64.spen, i64.busy} !== 4'b1010) begin
      errors++; $display("FAIL release64 sclr_n/sclk/spen/busy got %b want 1010", {i64.sclr_n, i64.sclk, i64.spen, i64.busy});
    end
  endtask

  task automatic test_single();
    logic [7:0] cap; int rises, busy_n, dones; logic latch_ok;
    run8(8'hA5, cap, rises, busy_n, dones, latch_ok);
    checks += 5;
    if (cap !== 8'hA5) begin errors++; $display("FAIL single capture got %h want a5", cap); end
    if (rises != 8) begin errors++; $display("FAIL single rises got %0d want 8", rises); end
    if (busy_n != 17) begin errors++; $display("FAIL single busy cycles got %0d want 17", busy_n); end
    if (dones != 1) begin errors++; $display("FAIL single done count got %0d want 1", dones); end
    if (latch_ok !== 1'b1) begin errors++; $display("FAIL single spen rise with done got %b want 1", latch_ok); end
    @(negedge clk);
    checks++;
    if ({i8.done, i8.busy, i8.spen} !== 3'b001) begin
      errors++; $display("FAIL single after done done/busy/spen got %b want 001", {i8.done, i8.busy, i8.spen});
    end
  endtask

  task automatic test_defaults();
    logic [63:0] cap = '0;
    int rises = 0, busy_n = 0, dones = 0;
    logic ps = i64.sclk;
    i64.start = 1'b1; i64.data = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      i64.start = 1'b0;
      if (!ps && i64.sclk) begin cap = {cap[62:0], i64.sdo}; rises++; end
      if (i64.busy) busy_n++;
      if (i64.done) dones++;
      ps = i64.sclk;
    end
    checks += 4;
    if (cap !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL defaults capture got %h want 0123456789abcdef", cap); end
    if (rises != 64) begin errors++; $display("FAIL defaults rises got %0d want 64", rises); end
    if (busy_n != 258) begin errors++; $display("FAIL defaults busy cycles got %0d want 258", busy_n); end
    if (dones != 1) begin errors++; $display("FAIL defaults done count got %0d want 1", dones); end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] cap = '0;
    int dones = 0;
    logic ps = i8.sclk;
    i8.start = 1'b1; i8.data = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ps && i8.sclk) cap = {cap[6:0], i8.sdo};
      if (i8.done) dones++;
      ps = i8.sclk;
      i8.start = c == 4;
      i8.data = c >= 4 ? 8'h00 : 8'hFF;
    end
    checks += 3;
    if (dones != 1) begin errors++; $display("FAIL ignore done count got %0d want 1", dones); end
    if (cap !== 8'hFF) begin errors++; $display("FAIL ignore capture got %h want ff", cap); end
    if (i8.busy !== 1'b0) begin errors++; $display("FAIL ignore queued busy got %b want 0", i8.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cap = '0;
    int transfers = 0;
    logic after_done = 1'b0;
    logic ps = i8.sclk;
    i8.start = 1'b1; i8.data = 8'h3C;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (!ps && i8.sclk) cap = {cap[6:0], i8.sdo};
      ps = i8.sclk;
      if (after_done) begin
        checks++;
        if ({i8.busy, i8.spen} !== 2'b10) begin
          errors++; $display("FAIL b2b restart busy/spen got %b want 10", {i8.busy, i8.spen});
        end
        after_done = 1'b0;
      end
      if (i8.done) begin
        checks++;
        if (cap !== 8'h3C) begin errors++; $display("FAIL b2b capture got %h want 3c", cap); end
        cap = '0; transfers++; after_done = 1'b1;
      end
    end
    i8.start = 1'b0;
    checks++;
    if (transfers != 3) begin errors++; $display("FAIL b2b transfer count got %0d want 3", transfers); end
    for (int c = 0; c < 40 && i8.busy; c++) @(negedge clk);
    checks++;
    if (i8.busy !== 1'b0) begin errors++; $display("FAIL b2b drain busy got %b want 0", i8.busy); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] cap; int rises = 0, busy_n, dones; logic latch_ok;
    logic ps = i8.sclk;
    i8.start = 1'b1; i8.data = 8'hC3;
    for (int c = 0; c < 30 && rises < 4; c++) begin
      @(negedge clk);
      i8.start = 1'b0;
      if (!ps && i8.sclk) rises++;
      ps = i8.sclk;
    end
    checks++;
    if (rises != 4) begin errors++; $display("FAIL midreset reached rises got %0d want 4", rises); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i8.sclk, i8.sdo, i8.spen, i8.sclr_n, i8.busy, i8.done} !== 6'b001000) begin
      errors++; $display("FAIL midreset pins got %b want 001000", {i8.sclk, i8.sdo, i8.spen, i8.sclr_n, i8.busy, i8.done});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (i8.done !== 1'b0) begin errors++; $display("FAIL midreset done got %b want 0", i8.done); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h81, cap, rises, busy_n, dones, latch_ok);
    checks += 3;
    if (cap !== 8'h81) begin errors++; $display("FAIL midreset recover capture got %h want 81", cap); end
    if (dones != 1) begin errors++; $display("FAIL midreset recover done count got %0d want 1", dones); end
    if (busy_n != 17) begin errors++; $display("FAIL midreset recover busy cycles got %0d want 17", busy_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_defaults();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
